// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract unit that processes CHUNK bits per clock.
// A request latches the operands, RUN walks the chunks from LSB to MSB with a
// rippled carry, and the final chunk edge publishes the result and flags.
// Results and flags hold steady until the next completion.

module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject configurations where the chunks do not tile the word exactly.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtract ops
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic             r_logic;
    logic [WIDTH-1:0] r_s;
    logic             r_of;
    logic             r_sf;
    logic             r_zf;

    logic             w_accept;
    logic             w_last;
    logic [IDX_W-1:0] w_base;
    logic [CHUNK-1:0] w_a_chk;
    logic [CHUNK-1:0] w_b_chk;
    logic [CHUNK:0]   w_chk_full;
    logic [CHUNK-1:0] w_chk_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_sov;
    logic             w_of;

    // A new request is taken from IDLE or from DONE (back-to-back); RUN ignores start.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(N - 1));

    // Chunk k occupies bits k*CHUNK .. k*CHUNK+CHUNK-1.
    assign w_base     = IDX_W'(r_cnt) * IDX_W'(CHUNK);
    assign w_a_chk    = r_a[w_base +: CHUNK];
    assign w_b_chk    = r_b[w_base +: CHUNK];
    assign w_chk_full = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
    assign w_chk_sum  = w_chk_full[CHUNK-1:0];
    assign w_cout     = w_chk_full[CHUNK];

    // Partial sum with the current chunk merged in; complete on the last chunk.
    always_comb begin
        w_sum_next                   = r_sum;
        w_sum_next[w_base +: CHUNK]  = w_chk_sum;
    end

    // Signed overflow compares the sign of a with the sign of the (possibly inverted) b.
    assign w_sov = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
    // Logical ops report carry-out for add and borrow (inverted carry) for subtract.
    assign w_of  = r_logic ? (r_sub ? ~w_cout : w_cout) : w_sov;

    // Control FSM with registered busy/done strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch on accept, then one chunk of ripple addition per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_logic <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op[0] ? ~b : b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= op[0];
            r_sub   <= op[0];
            r_logic <= op[1];
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result and flags change only on the edge that finishes the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= '0;
            r_of <= 1'b0;
            r_sf <= 1'b0;
            r_zf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_s  <= w_sum_next;
            r_of <= w_of;
            r_sf <= w_sum_next[WIDTH-1];
            r_zf <= (w_sum_next == '0);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign of   = r_of;
    assign sf   = r_sf;
    assign zf   = r_zf;

endmodule

// File: tb/tb_seq_addsub.sv
// Testbench for seq_addsub: directed corner cases plus randomized operations
// checked against an arithmetic reference model; a second instance covers CHUNK=WIDTH.

module tb_seq_addsub;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start2;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, of, sf, zf;
    logic [W-1:0] s;
    logic         busy2, done2, of2, sf2, zf2;
    logic [W-1:0] s2;

    int n_checks;
    int n_errors;

    seq_addsub #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .of(of), .sf(sf), .zf(zf)
    );

    seq_addsub #(.WIDTH(W), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start2), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .s(s2), .of(of2), .sf(sf2), .zf(zf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {of, result} from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        logic [W:0]   u;
        logic [W-1:0] res;
        logic         ovf;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            2'b00: begin r = sx + sy; res = x + y; ovf = (r > 32767) || (r < -32768); end
            2'b01: begin r = sx - sy; res = x - y; ovf = (r > 32767) || (r < -32768); end
            2'b10: begin u = {1'b0, x} + {1'b0, y}; res = u[W-1:0]; ovf = u[W]; end
            default: begin res = x - y; ovf = (x < y); end
        endcase
        return {ovf, res};
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns one negedge into RUN.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
        check("done_low_run", 32'(done), 32'd0);
    endtask

    // Runs RUN to completion while scrambling inputs and pulsing start, then checks results.
    task automatic wait_done(input logic [W:0] exp);
        int           waits;
        int           busy_cnt;
        bit           hold_ok;
        logic [W-1:0] s_prev;
        waits    = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        s_prev   = s;
        while ((done !== 1'b1) && (waits < 40)) begin
            if (busy === 1'b1) busy_cnt++;
            if (s !== s_prev) hold_ok = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            op    = 2'($urandom);
            start = 1'($urandom);
            @(negedge clk);
            waits++;
        end
        start = 1'b0;
        check("latency", 32'(waits), 32'(N));
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        check("s_hold_run", 32'(hold_ok), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("s", 32'(s), 32'(exp[W-1:0]));
        check("of", 32'(of), 32'(exp[W]));
        check("sf", 32'(sf), 32'(exp[W-1]));
        check("zf", 32'(zf), 32'(exp[W-1:0] == '0));
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] exp;
        exp = model(o, x, y);
        start_op(o, x, y);
        wait_done(exp);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("s_hold_idle", 32'(s), 32'(exp[W-1:0]));
    endtask

    initial begin
        logic [W:0] exp1;
        logic [W:0] exp2;
        bit         saw_done;
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_flags", {29'd0, of, sf, zf}, 32'd0);

        // Release reset and request in the same cycle: must be accepted at once.
        rst = 1'b0;
        do_op(2'b00, 16'h7FFF, 16'h0001);
        check("adda_s_const", 32'(s), 32'h8000);
        check("adda_of_const", 32'(of), 32'd1);
        do_op(2'b01, 16'h0005, 16'h0005);
        check("suba_zf_const", 32'(zf), 32'd1);
        do_op(2'b01, 16'h8000, 16'h0001);
        check("suba_of_const", 32'(of), 32'd1);
        do_op(2'b10, 16'hFFFF, 16'h0001);
        check("addl_of_const", 32'(of), 32'd1);
        do_op(2'b11, 16'h0001, 16'h0002);
        check("subl_s_const", 32'(s), 32'hFFFF);

        // Back-to-back: second request issued during the DONE cycle.
        exp1 = model(2'b00, 16'h1234, 16'h1111);
        exp2 = model(2'b11, 16'h0100, 16'h0200);
        start_op(2'b00, 16'h1234, 16'h1111);
        wait_done(exp1);
        check("b2b_first_s", 32'(s), 32'h2345);
        start_op(2'b11, 16'h0100, 16'h0200);
        wait_done(exp2);
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);

        // Reset two chunks into an operation aborts it with no done afterwards.
        start_op(2'b00, 16'h0F0F, 16'h0101);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            do_op(2'($urandom), W'($urandom), W'($urandom));
        end

        // Single-chunk instance: RUN lasts one cycle.
        op     = 2'b00;
        a      = 16'h0001;
        b      = 16'h0002;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("n1_busy", 32'(busy2), 32'd1);
        @(negedge clk);
        check("n1_done", 32'(done2), 32'd1);
        check("n1_s", 32'(s2), 32'h0003);
        check("n1_busy_off", 32'(busy2), 32'd0);
        @(negedge clk);
        check("n1_done_pulse", 32'(done2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request; sampled on rising edge.
REQ-006 op  input  2  operation: 00 ADDA, 01 SUBA, 10 ADDL, 11 SUBL.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 s  output  WIDTH  result.
REQ-012 of  output  1  overflow flag.
REQ-013 sf  output  1  sign flag, equal to s[WIDTH-1].
REQ-014 zf  output  1  zero flag, high when s is all zeros.

Function
REQ-015 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start=1 SHALL latch a, b and op internally, clear chunk counter, go to RUN.
REQ-017 Subtract ops: use ~b with carry-in 1; add ops: b with carry-in 0.
REQ-018 RUN: each edge adds chunk k (bits k*CHUNK+CHUNK-1..k*CHUNK) with carry from chunk k-1, stores the chunk sum and carry, increments k.
REQ-019 After the edge that processes chunk N-1, go to DONE; s, of, sf, zf update on that same edge.
REQ-020 Latency: done SHALL be high in the cycle after the N-th rising edge following the edge that sampled start.
REQ-021 busy=1 in RUN only; done=1 in DONE only, for exactly one cycle.
REQ-022 ADDA/SUBA: of = signed overflow (operand sign bits equal after inversion, result sign differs).
REQ-023 ADDL: of = final carry-out; SUBL: of = borrow = NOT final carry-out.
REQ-024 Result width is WIDTH; carry beyond the MSB is discarded except as reported in REQ-023.
REQ-025 s, of, sf, zf SHALL hold their values from completion until the next completion; they SHALL NOT change during RUN.
REQ-026 start while in RUN SHALL be ignored; a, b, op changes during RUN SHALL NOT affect the result.
REQ-027 DONE: start=1 SHALL be accepted as in REQ-016 (back-to-back); otherwise go to IDLE.
REQ-028 N=1 (CHUNK=WIDTH) SHALL be supported: RUN lasts one cycle.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, regardless of clk; busy=0, done=0, s=0, of=0, sf=0, zf=0; internal operands and counter cleared.
REQ-030 Reset during RUN SHALL abort the operation; no done pulse follows.
REQ-031 First start after rst release SHALL be accepted on the first rising edge where rst=0.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 ADDA 0x7FFF+0x0001 -> done after 4 edges; s=0x8000, of=1, sf=1, zf=0; busy high for exactly 4 cycles.
REQ-033 SUBA 0x0005-0x0005 -> s=0x0000, zf=1, of=0, sf=0; SUBA 0x8000-0x0001 -> s=0x7FFF, of=1.
REQ-034 ADDL 0xFFFF+0x0001 -> s=0x0000, of=1, zf=1; SUBL 0x0001-0x0002 -> s=0xFFFF, of=1, sf=1.
REQ-035 Start ADDA 0x1234+0x1111, change a/b/op and pulse start during RUN -> s=0x2345 and one done pulse; start held in DONE -> second operation follows with no IDLE cycle.
REQ-036 rst pulsed during RUN (after 2 chunks) -> busy=0, done=0, s=0 at once; no done for 10 cycles after.
REQ-037 CHUNK=16: ADDA 0x0001+0x0002 -> s=0x0003, done after 1 edge.
